// File: rtl/mem_lsu_stage.sv
// MEM stage between EX and WB. It tracks outstanding data-port requests, buffers early
// responses, discards responses that belong to flushed instructions, and extends load data.
module mem_lsu_stage #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned SIDE_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_issue,
    output logic              issue_stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wait_data,
    input  logic              in_ld_en,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_sign,
    input  logic [1:0]        in_addr_lo,
    input  logic [31:0]       in_result,
    input  logic [SIDE_W-1:0] in_side,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [SIDE_W-1:0] out_side,
    output logic              ld_busy
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW-1:0] MaxCnt  = CW'(MAX_OUT);
    localparam logic [PW-1:0] LastPtr = PW'(MAX_OUT - 1);

    logic              valid_q, wait_q, ld_en_q, ld_sign_q;
    logic [1:0]        ld_size_q, addr_lo_q;
    logic [31:0]       result_q;
    logic [SIDE_W-1:0] side_q;

    logic [CW-1:0] ocnt_q, ocnt_d, dcnt_q, dcnt_d, fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   fifo_mem [MAX_OUT];
    logic [31:0]   head;

    logic have_data, fifo_full, push, pop, accept, retire;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign ocnt_d    = ocnt_q + CW'(req_issue) - CW'(data_sram_data_ok);
    assign have_data = (fifo_cnt_q != '0);
    assign fifo_full = (fifo_cnt_q == MaxCnt);
    // Responses owed to flushed instructions are dropped until dcnt drains.
    assign push      = data_sram_data_ok & (dcnt_q == '0) & ~flush;
    assign out_valid = valid_q & (~wait_q | have_data);
    assign retire    = out_valid & out_ready;
    assign pop       = retire & wait_q;
    assign in_ready  = ~valid_q | retire;
    assign accept    = in_valid & in_ready & ~flush;
    assign head      = fifo_mem[rd_ptr_q];

    // Reserving FIFO space for every outstanding request makes overflow impossible.
    assign issue_stall = (({1'b0, ocnt_q} + {1'b0, fifo_cnt_q}) == {1'b0, MaxCnt});
    assign ld_busy     = valid_q & ld_en_q & ~have_data;
    assign out_side    = side_q;

    always_comb begin
        ld_byte = head[7:0];
        unique case (addr_lo_q)
            2'd0: ld_byte = head[7:0];
            2'd1: ld_byte = head[15:8];
            2'd2: ld_byte = head[23:16];
            2'd3: ld_byte = head[31:24];
        endcase
        ld_half = addr_lo_q[1] ? head[31:16] : head[15:0];
        case (ld_size_q)
            2'd0:    ld_ext = {{24{ld_sign_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = {{16{ld_sign_q & ld_half[15]}}, ld_half};
            default: ld_ext = head;
        endcase
        out_result = ld_en_q ? ld_ext : result_q;
    end

    always_comb begin
        dcnt_d = dcnt_q;
        if (flush) begin
            dcnt_d = ocnt_d;
        end else if (data_sram_data_ok && dcnt_q != '0) begin
            dcnt_d = dcnt_q - CW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ocnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
            dcnt_q <= dcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= data_sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            wait_q    <= 1'b0;
            ld_en_q   <= 1'b0;
            ld_sign_q <= 1'b0;
            ld_size_q <= 2'd0;
            addr_lo_q <= 2'd0;
            result_q  <= '0;
            side_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            wait_q    <= in_wait_data;
            ld_en_q   <= in_ld_en;
            ld_sign_q <= in_ld_sign;
            ld_size_q <= in_ld_size;
            addr_lo_q <= in_addr_lo;
            result_q  <= in_result;
            side_q    <= in_side;
        end else if (retire) begin
            valid_q <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && fifo_full)) else $error("response FIFO overflow");
    end
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Scoreboard bench for mem_lsu_stage: expected retirements are queued when stimulus is
// driven and compared by a monitor whenever the stage hands a result to WB.
module tb_mem_lsu_stage;

    localparam int SIDE_W = 128;

    logic              clk = 1'b0;
    logic              reset, flush, req_issue, issue_stall;
    logic              in_valid, in_ready, in_wait_data, in_ld_en, in_ld_sign;
    logic [1:0]        in_ld_size, in_addr_lo;
    logic [31:0]       in_result;
    logic [SIDE_W-1:0] in_side;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              out_valid, out_ready, ld_busy;
    logic [31:0]       out_result;
    logic [SIDE_W-1:0] out_side;

    typedef struct packed {
        logic [31:0]       res;
        logic [SIDE_W-1:0] side;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_lsu_stage #(.MAX_OUT(2), .SIDE_W(SIDE_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .req_issue         (req_issue),
        .issue_stall       (issue_stall),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_wait_data      (in_wait_data),
        .in_ld_en          (in_ld_en),
        .in_ld_size        (in_ld_size),
        .in_ld_sign        (in_ld_sign),
        .in_addr_lo        (in_addr_lo),
        .in_result         (in_result),
        .in_side           (in_side),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_side          (out_side),
        .ld_busy           (ld_busy)
    );

    always #5 clk = ~clk;

    // Retirement monitor: every handshake toward WB must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected: got result %h, required no retirement",
                         out_result);
            end else begin
                e = sb_q.pop_front();
                if (out_result !== e.res || out_side !== e.side) begin
                    n_fail++;
                    $display("FAIL retire_data: got result %h side %h, required %h side %h",
                             out_result, out_side[31:0], e.res, e.side[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; req_issue = 0; data_ok = 0; flush = 0; rdata = '0;
        in_wait_data = 0; in_ld_en = 0; in_ld_size = 0; in_ld_sign = 0; in_addr_lo = 0;
        in_result = '0; in_side = '0; out_ready = 1;
    endtask

    task automatic drive_alu(input logic [31:0] res, input logic [31:0] tag);
        in_valid = 1; in_wait_data = 0; in_ld_en = 0; in_result = res;
        in_side = {96'd0, tag};
    endtask

    task automatic drive_load(input logic [1:0] size, input logic sign, input logic [1:0] addr,
                              input logic [31:0] tag);
        in_valid = 1; in_wait_data = 1; in_ld_en = 1; in_ld_size = size; in_ld_sign = sign;
        in_addr_lo = addr; in_result = 32'h5A5A_0000; in_side = {96'd0, tag};
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_checks++; if (issue_stall !== 1'b0) begin n_fail++;
            $display("FAIL reset_issue_stall: got %b required 0", issue_stall); end
        n_checks++; if (ld_busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_ld_busy: got %b required 0", ld_busy); end
        n_checks++; if (out_result !== 32'd0 || out_side !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got result %h side %h required 0", out_result,
                     out_side[31:0]); end
        n_checks++; if (dut.ocnt_q !== 2'd0 || dut.dcnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd0)
            begin n_fail++;
            $display("FAIL reset_counters: got ocnt %0d dcnt %0d fifo %0d required 0 0 0",
                     dut.ocnt_q, dut.dcnt_q, dut.fifo_cnt_q); end
    endtask

    task automatic test_back_to_back();
        idle();
        drive_alu(32'h11, 32'h1);
        sb_q.push_back('{res: 32'h11, side: {96'd0, 32'h1}});
        step();
        drive_alu(32'h22, 32'h2);
        sb_q.push_back('{res: 32'h22, side: {96'd0, 32'h2}});
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b_first: got valid %b ready %b required 1 1", out_valid, in_ready);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL b2b_second: got valid %b required 1", out_valid); end
        step();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || dut.ocnt_q !== 2'd0) begin n_fail++;
            $display("FAIL b2b_drain: got valid %b ocnt %0d required 0 0", out_valid,
                     dut.ocnt_q); end
    endtask

    task automatic do_late_load(input logic [1:0] size, input logic sign, input logic [1:0] addr,
                                input logic [31:0] data, input logic [31:0] expv,
                                input logic [31:0] tag);
        idle();
        drive_load(size, sign, addr, tag);
        req_issue = 1;
        sb_q.push_back('{res: expv, side: {96'd0, tag}});
        step();
        idle();
        @(negedge clk);
        n_checks++; if (ld_busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL load_wait: got busy %b valid %b required 1 0", ld_busy, out_valid);
        end
        step();
        data_ok = 1;
        rdata = data;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL load_early_valid: got valid %b required 0", out_valid); end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || ld_busy !== 1'b0) begin n_fail++;
            $display("FAIL load_latency: got valid %b busy %b required 1 0", out_valid,
                     ld_busy); end
        step();
    endtask

    task automatic test_load_ext();
        do_late_load(2'd0, 1'b1, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 32'h10);
        do_late_load(2'd1, 1'b0, 2'd2, 32'h80FF_0000, 32'h0000_80FF, 32'h11);
        @(negedge clk);
        n_checks++; if (dut.ocnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd0) begin n_fail++;
            $display("FAIL load_counters: got ocnt %0d fifo %0d required 0 0", dut.ocnt_q,
                     dut.fifo_cnt_q); end
    endtask

    task automatic test_early_data();
        idle();
        req_issue = 1;
        step();
        req_issue = 1; data_ok = 1; rdata = 32'hDEAD_BEEF;
        step();
        idle();
        data_ok = 1; rdata = 32'h0000_F00D;
        step();
        idle();
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1 || dut.ocnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd2)
            begin n_fail++;
            $display("FAIL early_stall: got stall %b ocnt %0d fifo %0d required 1 0 2",
                     issue_stall, dut.ocnt_q, dut.fifo_cnt_q); end
        drive_load(2'd2, 1'b0, 2'd0, 32'h20);
        sb_q.push_back('{res: 32'hDEAD_BEEF, side: {96'd0, 32'h20}});
        step();
        drive_load(2'd1, 1'b1, 2'd0, 32'h21);
        sb_q.push_back('{res: 32'hFFFF_F00D, side: {96'd0, 32'h21}});
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL early_first: got valid %b ready %b required 1 1", out_valid,
                     in_ready); end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL early_second: got valid %b required 1", out_valid); end
        step();
        @(negedge clk);
        n_checks++; if (dut.fifo_cnt_q !== 2'd0 || issue_stall !== 1'b0) begin n_fail++;
            $display("FAIL early_drain: got fifo %0d stall %b required 0 0", dut.fifo_cnt_q,
                     issue_stall); end
    endtask

    task automatic test_wb_stall();
        idle();
        drive_alu(32'h55, 32'h30);
        sb_q.push_back('{res: 32'h55, side: {96'd0, 32'h30}});
        step();
        idle();
        out_ready = 0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h55) begin
            n_fail++;
            $display("FAIL stall_hold: got valid %b ready %b result %h required 1 0 00000055",
                     out_valid, in_ready, out_result); end
        step();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h55) begin n_fail++;
            $display("FAIL stall_hold2: got valid %b result %h required 1 00000055", out_valid,
                     out_result); end
        step();
        out_ready = 1;
        step();
    endtask

    task automatic test_flush_discard();
        idle();
        drive_load(2'd2, 1'b0, 2'd0, 32'h40);
        req_issue = 1;
        step();
        idle();
        req_issue = 1;
        step();
        idle();
        flush = 1;
        step();
        idle();
        @(negedge clk);
        n_checks++; if (dut.dcnt_q !== 2'd2 || dut.ocnt_q !== 2'd2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dcnt: got dcnt %0d ocnt %0d valid %b required 2 2 0",
                     dut.dcnt_q, dut.ocnt_q, out_valid); end
        // New request issued while the stale responses are still being dropped.
        data_ok = 1; rdata = 32'hBAD0_0001; req_issue = 1;
        drive_load(2'd2, 1'b0, 2'd0, 32'h41);
        sb_q.push_back('{res: 32'h0000_1234, side: {96'd0, 32'h41}});
        step();
        idle();
        data_ok = 1; rdata = 32'hBAD0_0002;
        @(negedge clk);
        n_checks++; if (ld_busy !== 1'b1 || dut.dcnt_q !== 2'd1) begin n_fail++;
            $display("FAIL flush_drop1: got busy %b dcnt %0d required 1 1", ld_busy,
                     dut.dcnt_q); end
        step();
        idle();
        data_ok = 1; rdata = 32'h0000_1234;
        @(negedge clk);
        n_checks++; if (dut.dcnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd0 || out_valid !== 1'b0)
            begin n_fail++;
            $display("FAIL flush_drop2: got dcnt %0d fifo %0d valid %b required 0 0 0",
                     dut.dcnt_q, dut.fifo_cnt_q, out_valid); end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL flush_newreq: got valid %b required 1", out_valid); end
        step();
    endtask

    task automatic test_flush_same_cycle();
        idle();
        drive_load(2'd2, 1'b0, 2'd0, 32'h50);
        req_issue = 1;
        step();
        idle();
        flush = 1; req_issue = 1; data_ok = 1; rdata = 32'hBAD0_0003;
        drive_alu(32'h99, 32'h51);
        step();
        idle();
        @(negedge clk);
        n_checks++; if (dut.ocnt_q !== 2'd1 || dut.dcnt_q !== 2'd1 || dut.fifo_cnt_q !== 2'd0)
            begin n_fail++;
            $display("FAIL flush_same: got ocnt %0d dcnt %0d fifo %0d required 1 1 0",
                     dut.ocnt_q, dut.dcnt_q, dut.fifo_cnt_q); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL flush_same_stage: got valid %b ready %b required 0 1", out_valid,
                     in_ready); end
        data_ok = 1; rdata = 32'hBAD0_0004;
        step();
        idle();
        @(negedge clk);
        n_checks++; if (dut.ocnt_q !== 2'd0 || dut.dcnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd0)
            begin n_fail++;
            $display("FAIL flush_same_drain: got ocnt %0d dcnt %0d fifo %0d required 0 0 0",
                     dut.ocnt_q, dut.dcnt_q, dut.fifo_cnt_q); end
    endtask

    task automatic test_reset_mid();
        idle();
        drive_load(2'd2, 1'b0, 2'd0, 32'h60);
        req_issue = 1;
        step();
        idle();
        req_issue = 1;
        step();
        idle();
        @(negedge clk);
        n_checks++; if (dut.ocnt_q !== 2'd2 || ld_busy !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_pre: got ocnt %0d busy %b required 2 1", dut.ocnt_q,
                     ld_busy); end
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        n_checks++; if (dut.ocnt_q !== 2'd0 || dut.dcnt_q !== 2'd0 || dut.fifo_cnt_q !== 2'd0)
            begin n_fail++;
            $display("FAIL rstmid_counters: got ocnt %0d dcnt %0d fifo %0d required 0 0 0",
                     dut.ocnt_q, dut.dcnt_q, dut.fifo_cnt_q); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_outputs: got valid %b ready %b required 0 1", out_valid,
                     in_ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_ext();
        test_early_data();
        test_wb_stall();
        test_flush_discard();
        test_flush_same_cycle();
        test_reset_mid();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending retirements required 0",
                     sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
